// File: rtl/rr_issue_scheduler.sv
// Round-robin multi-issue scheduler: pending bitmap plus rotating start pointer,
// offering up to ISSUE_NUM pending ids per cycle and retiring the accepted prefix.
module rr_issue_scheduler #(
  parameter int unsigned ITEM_NUM  = 8,
  parameter int unsigned ISSUE_NUM = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [ITEM_NUM-1:0]           set_mask,
  output logic [$clog2(ITEM_NUM)-1:0]   issue_id [ISSUE_NUM],
  output logic [ISSUE_NUM-1:0]          issue_valid,
  input  logic [ISSUE_NUM-1:0]          issue_ready,
  output logic [$clog2(ITEM_NUM)-1:0]   ptr,
  output logic [ITEM_NUM-1:0]           pending,
  output logic [$clog2(ITEM_NUM):0]     pending_count
);

  localparam int unsigned IDW = $clog2(ITEM_NUM);
  localparam int unsigned CW  = IDW + 1;

  logic [ITEM_NUM-1:0]  pending_q, pending_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [ISSUE_NUM-1:0] accept;
  logic [ITEM_NUM-1:0]  accepted_bits;
  logic [IDW-1:0]       last_id;

  // Walk entries starting at ptr_q; slot counts pending entries seen so far,
  // so an entry lands on lane k when exactly k pending entries precede it.
  always_comb begin
    logic [CW-1:0]  slot;
    logic [IDW-1:0] idx;
    slot = '0;
    idx  = '0;
    issue_valid = '0;
    for (int unsigned k = 0; k < ISSUE_NUM; k++) begin
      issue_id[k] = '0;
    end
    for (int unsigned i = 0; i < ITEM_NUM; i++) begin
      idx = ptr_q + IDW'(i);
      for (int unsigned k = 0; k < ISSUE_NUM; k++) begin
        if (pending_q[idx] && slot == CW'(k)) begin
          issue_id[k]    = idx;
          issue_valid[k] = 1'b1;
        end
      end
      if (pending_q[idx]) begin
        slot = slot + CW'(1);
      end
    end
    pending_count = slot;
  end

  always_comb begin
    logic run;
    run           = 1'b1;
    accept        = '0;
    accepted_bits = '0;
    last_id       = ptr_q;
    for (int unsigned k = 0; k < ISSUE_NUM; k++) begin
      run       = run & issue_valid[k] & issue_ready[k];
      accept[k] = run;
      if (run) begin
        accepted_bits[issue_id[k]] = 1'b1;
        last_id                    = issue_id[k];
      end
    end
  end

  always_comb begin
    pending_d = (pending_q & ~accepted_bits) | set_mask;
    ptr_d     = accept[0] ? last_id + IDW'(1) : ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pending_q <= '0;
      ptr_q     <= '0;
    end else begin
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
    end
  end

  assign pending = pending_q;
  assign ptr     = ptr_q;

endmodule

// File: tb/tb_rr_issue_scheduler.sv
// Directed and model-checked bench for rr_issue_scheduler (ITEM_NUM=8, ISSUE_NUM=4).
module tb_rr_issue_scheduler;

  logic       clk = 1'b0;
  logic       rst, flush;
  logic [7:0] set_mask;
  logic [2:0] issue_id [4];
  logic [3:0] issue_valid, issue_ready;
  logic [2:0] ptr;
  logic [7:0] pending;
  logic [3:0] pending_count;

  int checks = 0;
  int errors = 0;

  rr_issue_scheduler #(.ITEM_NUM(8), .ISSUE_NUM(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .set_mask      (set_mask),
    .issue_id      (issue_id),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .ptr           (ptr),
    .pending       (pending),
    .pending_count (pending_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ids();
    logic [11:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v = {v[8:0], issue_id[k]};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    set_mask    = '0;
    issue_ready = '0;
    flush       = 1'b0;
    rst         = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
  endtask

  // Reference model state
  logic [7:0] m_pend;
  logic [2:0] m_ptr;

  initial begin
    rst = 1'b1; flush = 1'b0; set_mask = '0; issue_ready = '0;
    tick();
    do_reset();

    check("rst_pending", pending, 8'h00);
    check("rst_ptr", ptr, 3'd0);
    check("rst_count", pending_count, 4'd0);
    check("rst_valid", issue_valid, 4'b0000);
    check("rst_ids", ids(), 12'h000);

    set_mask = 8'b10100110;
    tick();
    check("set_ids", ids(), {3'd1, 3'd2, 3'd5, 3'd7});
    check("set_valid", issue_valid, 4'b1111);
    check("set_count", pending_count, 4'd4);
    check("set_ptr", ptr, 3'd0);

    issue_ready = 4'b0011;
    tick();
    check("acc2_pending", pending, 8'b10100000);
    check("acc2_ptr", ptr, 3'd3);
    check("acc2_ids", ids(), {3'd5, 3'd7, 3'd0, 3'd0});
    check("acc2_valid", issue_valid, 4'b0011);

    // Build pending=10000011, ptr=5 by accepting entry 4 while setting the new mask
    do_reset();
    set_mask = 8'h10;
    tick();
    set_mask = 8'b10000011; issue_ready = 4'b0001;
    tick();
    check("wrap_pending", pending, 8'b10000011);
    check("wrap_ptr", ptr, 3'd5);
    check("wrap_ids", ids(), {3'd7, 3'd0, 3'd1, 3'd0});
    check("wrap_valid", issue_valid, 4'b0111);
    issue_ready = 4'b1111;
    tick();
    check("wrapacc_pending", pending, 8'h00);
    check("wrapacc_ptr", ptr, 3'd2);
    check("wrapacc_valid", issue_valid, 4'b0000);
    check("empty_count", pending_count, 4'd0);
    issue_ready = 4'b1111;
    tick();
    check("empty_ptr_hold", ptr, 3'd2);

    do_reset();
    set_mask = 8'b00001111;
    tick();
    issue_ready = 4'b1110;
    tick();
    check("prefix_pending", pending, 8'b00001111);
    check("prefix_ptr", ptr, 3'd0);

    do_reset();
    set_mask = 8'b00000001;
    tick();
    set_mask = 8'b00000001; issue_ready = 4'b0001;
    tick();
    check("setwin_pending", pending, 8'b00000001);
    check("setwin_ptr", ptr, 3'd1);
    check("setwin_id0", {29'd0, issue_id[0]}, 32'd0);
    check("setwin_valid", issue_valid, 4'b0001);

    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      set_mask = 8'h20;
      tick();
      set_mask = 8'hFF; issue_ready = 4'b0001;
      tick();
      check("full_pending", pending, 8'hFF);
      check("full_ptr", ptr, 3'd6);
      check("full_count", pending_count, 4'd8);
      check("full_ids", ids(), {3'd6, 3'd7, 3'd0, 3'd1});
      set_mask = 8'h0F; issue_ready = 4'b1111;
      if (pass == 0) flush = 1'b1; else rst = 1'b1;
      tick();
      check(pass == 0 ? "flush_pending" : "rstmid_pending", pending, 8'h00);
      check(pass == 0 ? "flush_ptr" : "rstmid_ptr", ptr, 3'd0);
      check(pass == 0 ? "flush_valid" : "rstmid_valid", issue_valid, 4'b0000);
    end

    // Random run against a walk-based reference model
    do_reset();
    m_pend = '0;
    m_ptr  = '0;
    for (int cyc = 0; cyc < 65536; cyc++) begin
      logic [11:0] e_ids;
      logic [3:0]  e_valid, e_cnt;
      logic [2:0]  lane_id [4];
      logic [2:0]  idx, last;
      logic        run, any;
      logic [7:0]  n_pend;
      int          n;
      n = 0;
      e_valid = '0;
      for (int k = 0; k < 4; k++) lane_id[k] = '0;
      for (int j = 0; j < 8; j++) begin
        idx = 3'((int'(m_ptr) + j) % 8);
        if (m_pend[idx]) begin
          if (n < 4) begin
            lane_id[n] = idx;
            e_valid[n] = 1'b1;
          end
          n++;
        end
      end
      e_cnt = 4'(n);
      e_ids = {lane_id[0], lane_id[1], lane_id[2], lane_id[3]};
      check("rand_state", {5'd0, pending, ptr, pending_count, issue_valid, ids()},
            {5'd0, m_pend, m_ptr, e_cnt, e_valid, e_ids});

      flush       = ($urandom_range(0, 99) == 0);
      set_mask    = 8'($urandom & $urandom & $urandom);
      issue_ready = 4'($urandom);
      if ($urandom_range(0, 3) == 0) issue_ready = 4'b1111;

      run = 1'b1; any = 1'b0; last = m_ptr; n_pend = m_pend;
      for (int k = 0; k < 4; k++) begin
        run = run && e_valid[k] && issue_ready[k];
        if (run) begin
          n_pend[lane_id[k]] = 1'b0;
          last = lane_id[k];
          any  = 1'b1;
        end
      end
      if (flush) begin
        m_pend = '0;
        m_ptr  = '0;
      end else begin
        m_pend = n_pend | set_mask;
        if (any) m_ptr = last + 3'd1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_issue_scheduler.md
# rr_issue_scheduler

Round-robin multi-issue scheduler that holds a pending bitmap of ITEM_NUM entries and offers up to ISSUE_NUM entry ids per cycle. Entries are offered in rotating order, starting at a registered pointer. It sits directly upstream of the rotating enabled-item list stage: it owns the `seq` bitmap and the `start_pos` pointer, uses the rotated id list to drive its issue lanes, and retires accepted entries. Consumers are issue and commit ports that take a contiguous prefix of the offered lanes each cycle.

## Interface
- ITEM_NUM, 8, number of tracked entries; power of two, ≥ 2
- ISSUE_NUM, 4, number of issue lanes; 1 ≤ ISSUE_NUM ≤ ITEM_NUM
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  clears all pending entries and the pointer
- set_mask  input  ITEM_NUM  entries to mark pending; sampled at clk rising edge
- issue_id[0:ISSUE_NUM-1]  output  $clog2(ITEM_NUM) each  offered entry id per lane
- issue_valid  output  ISSUE_NUM  lane k carries a pending entry
- issue_ready  input  ISSUE_NUM  consumer accepts lane k
- ptr  output  $clog2(ITEM_NUM)  current round-robin start position
- pending  output  ITEM_NUM  registered pending bitmap
- pending_count  output  $clog2(ITEM_NUM)+1  popcount of pending

## Operation
- State consists of two registers, `pending[ITEM_NUM]` and `ptr`. All outputs are combinational functions of this state and `issue_ready`. There is no bypass from `set_mask` to the lanes.
- Lane ordering:
  - Walk the pending entries from `ptr` upward to ITEM_NUM-1, then wrap from 0 to `ptr`-1.
  - Lane k holds the k-th pending entry in that walk.
  - `issue_valid[k]` = (pending_count > k).
  - When a lane is invalid, its `issue_id[k]` is 0.
- Acceptance uses a prefix rule. Lane k is accepted iff, for every j ≤ k, `issue_valid[j]` and `issue_ready[j]` are both 1. A ready lane that follows a non-accepted lane is not accepted. `issue_ready` on an invalid lane is ignored.
- Next-state logic, in priority order:
  - rst: pending ← 0, ptr ← 0.
  - flush: pending ← 0, ptr ← 0. `set_mask` in the same cycle is discarded.
  - Otherwise:
    - pending ← (pending & ~accepted_bits) | set_mask.
    - If at least one lane is accepted, ptr ← (issue_id[last accepted lane] + 1) mod ITEM_NUM.
    - If no lane is accepted, ptr is unchanged.
- If a bit is accepted and set in the same cycle, the set wins and the entry stays pending; it is re-offered next cycle under the new ptr.
- Setting an already-pending bit has no effect and is not an error.
- The block reuses the enabled-item list logic (`seq` = pending, `start_pos` = ptr) and takes its first ISSUE_NUM ids.

## Timing
- Reset values: pending = 0, ptr = 0, pending_count = 0, issue_valid = 0, every issue_id = 0.
- Latency from set to offer: `set_mask` bit sampled at edge t appears on `issue_valid` and `issue_id` after edge t, i.e. one cycle later.
- Latency from accept to clear: an entry accepted in cycle t is absent from `pending` after edge t. `ptr` updates at the same edge.
- Throughput: up to ISSUE_NUM accepts per cycle, sustained.
- Full: all ITEM_NUM entries pending is legal. The lanes show ptr, ptr+1, … mod ITEM_NUM.
- Empty: all lanes are invalid, ptr holds, pending_count = 0.
- Wrap-around: the ptr update is modulo ITEM_NUM. An accept of entry ITEM_NUM-1 sets ptr to 0.
- rst or flush asserted mid-operation takes effect at the next edge regardless of `issue_ready`. Lanes accepted in that cycle are dropped silently, and the consumer must not count them.

## Test plan
All scenarios use ITEM_NUM = 8 and ISSUE_NUM = 4.
- Reset then set_mask = 8'b10100110 for one cycle.
  - Next cycle: issue_id = {1,2,5,7}, issue_valid = 4'b1111, pending_count = 4, ptr = 0.
- From the state above, issue_ready = 4'b0011, so lanes 0 and 1 are accepted.
  - Next cycle: pending = 8'b10100000, ptr = 3, issue_id = {5,7,0,0}, valid = 4'b0011.
- Wrap case: pending = 8'b10000011, ptr = 5.
  - Lanes show {7,0,1}, valid = 4'b0111.
  - Accept all: next cycle pending = 0, ptr = 2, valid = 0.
- Prefix rule: pending = 8'b00001111, ptr = 0, issue_ready = 4'b1110.
  - Nothing is accepted: pending is unchanged and ptr stays 0.
- Set wins over accept: pending = 8'b00000001, lane 0 accepted and set_mask = 8'b00000001 in the same cycle.
  - Next cycle: pending = 8'b00000001, ptr = 1, lane 0 shows id 0 valid.
- Flush priority: pending = 8'hFF, ptr = 6; assert flush with set_mask = 8'h0F and issue_ready = 4'b1111.
  - Next cycle: pending = 0, ptr = 0, valid = 0.
  - Repeat the same check with rst instead of flush; the result is identical.
- Random: 65536 cycles of random set_mask, issue_ready and rare flush, compared against a reference model every cycle. Checks cover ordering, the prefix rule, ptr and pending_count.
